seg7_scan_reader: RTL and testbench
===================================

// Module: seg7_scan_reader
// PURPOSE
//  Monitors a multiplexed, active-low 7-segment display bus (segments + digit anodes).
//  Qualifies stable scan slots and decodes each segment pattern back to a hex nibble.
//  Presents the reconstructed multi-digit value for self-check and readback logic.
//  It is the reader side of our hex-to-segment display path.
// PARAMETERS
//  DIGITS      4  number of multiplexed digits / anode lines (1..8)
//  STABLE_CYC  4  consecutive identical samples required before capture (2..255)
// PORTS
//  clk          in   1           system clock, rising edge
//  rst_n        in   1           asynchronous active-low reset
//  seg_n        in   8           segments, active-low; [6:0]=g,f,e,d,c,b,a; [7]=dp
//  an_n         in   DIGITS      digit selects, active-low; bit i = digit i (0 = least significant)
//  err_clr      in   1           clears err_flag
//  value        out  4*DIGITS    decoded nibbles; digit i at [4i+3:4i]
//  dp           out  DIGITS      captured decimal point per digit, active-high
//  digit_valid  out  DIGITS      1 = digit i holds a legal hex glyph; 0 = blank or never captured
//  frame_valid  out  1           1-cycle pulse: every digit captured since the last pulse
//  err_flag     out  1           sticky: illegal glyph captured
//  err_digit    out  3           index of the most recent illegal-glyph digit
// BEHAVIOUR
//  Reset:
//  - rst_n low clears all state asynchronously.
//  - Outputs go to value=0, dp=0, digit_valid=0, frame_valid=0, err_flag=0, err_digit=0.
//  - FSM goes to WAIT_SEL, stable counter to 0, capture mask to 0.
//  Input sampling:
//  - {an_n, seg_n} is registered once into in_q.
//  - cnt resets to 0 whenever in_q changes; otherwise it increments, saturating at STABLE_CYC-1.
//  FSM:
//  - WAIT_SEL: stay while zero or more than one an_n bit is low. Go to QUAL when exactly one is low.
//  - QUAL:
//    - in_q changes to another one-hot select: stay in QUAL, cnt=0.
//    - in_q changes to a non-one-hot select: go to WAIT_SEL.
//    - cnt reaches STABLE_CYC-1 with in_q unchanged: go to CAPTURE.
//  - CAPTURE (one cycle): update digit k (the active anode).
//    - Write value, dp and digit_valid for digit k and set capture_mask[k].
//    - Always go to HOLD.
//  - HOLD: no recapture while in_q is unchanged.
//    - Any change returns to QUAL (one-hot select) or WAIT_SEL (otherwise).
//    - This covers a new glyph on the same digit.
//  - Latency: inputs constant from edge E are sampled at E+1.
//    - Outputs update at edge E+1+STABLE_CYC (CAPTURE) and are visible after it.
//  Decode: x = ~seg_n[6:0] (gfedcba, active-high).
//  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
//  - Legal glyph: nibble written, digit_valid[k]=1.
//  - Blank (x=00): nibble=0, digit_valid[k]=0, no error.
//  - Any other x: nibble=0, digit_valid[k]=0, err_flag=1, err_digit=k.
//  - dp[k] = ~seg_n[7] in every case.
//  Frame:
//  - capture_mask becomes all ones in a CAPTURE cycle: frame_valid=1 for exactly the next cycle and mask clears.
//  - Recapturing an already-set digit does not advance the frame.
//  Errors:
//  - err_flag is cleared only by err_clr.
//  - err_clr in the same cycle as a new illegal capture: set wins.
//  Boundary:
//  - An anode change mid-QUAL discards the partial qualification; no write occurs.
//  - All anodes off (inter-digit blanking) is ignored.
//  - Reset during QUAL or CAPTURE loses the pending capture; there is no partial write.
// TESTING
//  1. Sweep digits 0..3 with glyphs 0x3F,0x06,0x5B,0x4F (seg_n=~x, dp off), each held 8 cycles
//     -> value=16'h3210, digit_valid=4'hF, one frame_valid pulse, err_flag=0.
//  2. Glitch: digit0 shows 0x7D for STABLE_CYC-1 cycles, then 0x07 held 8 cycles
//     -> value[3:0]=7, no capture of 6.
//  3. an_n=4'b1100 held 10 cycles -> no outputs change; FSM stays in WAIT_SEL.
//  4. Digit2 x=0x49 (illegal) -> err_flag=1, err_digit=2, digit_valid[2]=0.
//     Then err_clr pulse -> err_flag=0.
//  5. Digit1 shows blank with dp on (seg_n=8'h7F) -> value[7:4]=0, digit_valid[1]=0, dp[1]=1, err_flag=0.
//  6. Assert rst_n low two cycles into QUAL of digit3 -> all outputs 0 immediately.
//     After release, an 8-cycle hold of 0x71 gives value[15:12]=F.

Source files
------------

// File: rtl/seg7_scan_if.sv
// Bus between a multiplexed 7-segment display monitor and its consumer.
// The master drives the scanned display lines and reads back the decoded value.
interface seg7_scan_if #(
    parameter int DIGITS = 4
);
    logic [7:0]          seg_n;
    logic [DIGITS-1:0]   an_n;
    logic                err_clr;
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   dp;
    logic [DIGITS-1:0]   digit_valid;
    logic                frame_valid;
    logic                err_flag;
    logic [2:0]          err_digit;

    modport master (
        output seg_n, an_n, err_clr,
        input  value, dp, digit_valid, frame_valid, err_flag, err_digit
    );

    modport slave (
        input  seg_n, an_n, err_clr,
        output value, dp, digit_valid, frame_valid, err_flag, err_digit
    );
endinterface

// File: rtl/seg7_scan_reader.sv
// Reads a multiplexed active-low 7-segment bus back into hex nibbles: waits for a
// stable one-hot anode slot, decodes the glyph and tracks frame completion and errors.
module seg7_scan_reader #(
    parameter int DIGITS     = 4,
    parameter int STABLE_CYC = 4
) (
    input logic        clk,
    input logic        rst_n,
    seg7_scan_if.slave bus
);
    localparam int         W       = DIGITS + 8;
    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYC - 1);

    localparam logic [1:0] WAIT_SEL = 2'd0;
    localparam logic [1:0] QUAL     = 2'd1;
    localparam logic [1:0] CAPTURE  = 2'd2;
    localparam logic [1:0] HOLD     = 2'd3;

    // Returns {illegal, legal, nibble}; blank and illegal glyphs both yield nibble 0.
    function automatic logic [5:0] decode(input logic [6:0] x);
        case (x)
            7'h3F:   decode = {2'b01, 4'h0};
            7'h06:   decode = {2'b01, 4'h1};
            7'h5B:   decode = {2'b01, 4'h2};
            7'h4F:   decode = {2'b01, 4'h3};
            7'h66:   decode = {2'b01, 4'h4};
            7'h6D:   decode = {2'b01, 4'h5};
            7'h7D:   decode = {2'b01, 4'h6};
            7'h07:   decode = {2'b01, 4'h7};
            7'h7F:   decode = {2'b01, 4'h8};
            7'h6F:   decode = {2'b01, 4'h9};
            7'h77:   decode = {2'b01, 4'hA};
            7'h7C:   decode = {2'b01, 4'hB};
            7'h39:   decode = {2'b01, 4'hC};
            7'h5E:   decode = {2'b01, 4'hD};
            7'h79:   decode = {2'b01, 4'hE};
            7'h71:   decode = {2'b01, 4'hF};
            7'h00:   decode = {2'b00, 4'h0};
            default: decode = {2'b10, 4'h0};
        endcase
    endfunction

    function automatic logic [7:0] cnt_sat_inc(input logic [7:0] c);
        return (c == CNT_MAX) ? c : c + 8'd1;
    endfunction

    logic [W-1:0]        in_d;
    logic [W-1:0]        in_q;
    logic [W-1:0]        held_q;
    logic [7:0]          cnt;
    logic [1:0]          state;
    logic [DIGITS-1:0]   capture_mask;
    logic [DIGITS-1:0]   mask_next;
    logic [DIGITS-1:0]   sel;
    logic                sel_onehot;
    logic [2:0]          sel_idx;
    logic                fresh;
    logic                capture;
    logic [5:0]          glyph;

    logic [4*DIGITS-1:0] value_r;
    logic [DIGITS-1:0]   dp_r;
    logic [DIGITS-1:0]   digit_valid_r;
    logic                frame_valid_r;
    logic                err_flag_r;
    logic [2:0]          err_digit_r;

    assign in_d       = {bus.an_n, bus.seg_n};
    assign sel        = ~in_q[W-1:8];
    assign sel_onehot = (sel != '0) && ((sel & (sel - DIGITS'(1))) == '0);
    assign fresh      = (cnt == 8'd0);
    assign capture    = (state == QUAL) && !fresh && (cnt == CNT_MAX);
    assign glyph      = decode(~in_q[6:0]);
    assign mask_next  = capture_mask | sel;

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (sel[i]) sel_idx = 3'(i);
        end
    end

    // Input sample and stability counter: cnt counts how long in_q has been unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q <= '0;
            cnt  <= '0;
        end else begin
            in_q <= in_d;
            cnt  <= (in_d != in_q) ? 8'd0 : cnt_sat_inc(cnt);
        end
    end

    // Slot FSM; the digit write happens on the edge that enters CAPTURE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= WAIT_SEL;
            held_q <= '0;
        end else begin
            case (state)
                WAIT_SEL: if (sel_onehot) state <= QUAL;
                QUAL: begin
                    if (fresh) begin
                        if (!sel_onehot) state <= WAIT_SEL;
                    end else if (cnt == CNT_MAX) begin
                        state  <= CAPTURE;
                        held_q <= in_q;
                    end
                end
                CAPTURE: state <= HOLD;
                default: begin
                    // Compare against the captured slot so a change during CAPTURE is not missed.
                    if (in_q != held_q) state <= sel_onehot ? QUAL : WAIT_SEL;
                end
            endcase
        end
    end

    // Output registers, frame tracking and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_r       <= '0;
            dp_r          <= '0;
            digit_valid_r <= '0;
            frame_valid_r <= 1'b0;
            capture_mask  <= '0;
            err_flag_r    <= 1'b0;
            err_digit_r   <= '0;
        end else begin
            frame_valid_r <= 1'b0;
            if (capture) begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (sel[i]) begin
                        value_r[4*i +: 4] <= glyph[3:0];
                        digit_valid_r[i]  <= glyph[4];
                        dp_r[i]           <= ~in_q[7];
                    end
                end
                if (mask_next == '1) begin
                    frame_valid_r <= 1'b1;
                    capture_mask  <= '0;
                end else begin
                    capture_mask  <= mask_next;
                end
            end
            if (capture && glyph[5]) begin
                err_flag_r  <= 1'b1;
                err_digit_r <= sel_idx;
            end else if (bus.err_clr) begin
                err_flag_r  <= 1'b0;
            end
        end
    end

    assign bus.value       = value_r;
    assign bus.dp          = dp_r;
    assign bus.digit_valid = digit_valid_r;
    assign bus.frame_valid = frame_valid_r;
    assign bus.err_flag    = err_flag_r;
    assign bus.err_digit   = err_digit_r;
endmodule

// File: tb/tb_seg7_scan_reader.sv
// Directed bench for seg7_scan_reader: digit sweep, glitch rejection, multi-anode,
// illegal glyph, blank digit, frame pulse and asynchronous reset mid-qualification.
module tb_seg7_scan_reader;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad = 0;
    int   fv_cnt = 0;

    seg7_scan_if #(.DIGITS(4)) bus ();

    seg7_scan_reader #(.DIGITS(4), .STABLE_CYC(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.frame_valid === 1'b1) fv_cnt++;
    end

    task automatic apply(input logic [3:0] an, input logic [7:0] seg);
        bus.an_n  = an;
        bus.seg_n = seg;
    endtask

    task automatic hold(input logic [3:0] an, input logic [7:0] seg, input int n);
        apply(an, seg);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n       = 1'b0;
        bus.err_clr = 1'b0;
        apply(4'hF, 8'hFF);
        #3;
        total++; if (bus.value !== 16'h0000) begin bad++; $display("FAIL reset_value got=%h exp=%h", bus.value, 16'h0000); end
        total++; if (bus.digit_valid !== 4'h0) begin bad++; $display("FAIL reset_dv got=%h exp=%h", bus.digit_valid, 4'h0); end
        total++; if (bus.dp !== 4'h0) begin bad++; $display("FAIL reset_dp got=%h exp=%h", bus.dp, 4'h0); end
        total++; if (bus.frame_valid !== 1'b0) begin bad++; $display("FAIL reset_fv got=%b exp=0", bus.frame_valid); end
        total++; if ({bus.err_flag, bus.err_digit} !== 4'h0) begin bad++; $display("FAIL reset_err got=%h exp=0", {bus.err_flag, bus.err_digit}); end
        total++; if (dut.state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", dut.state); end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_sweep;
        logic [7:0] segs [4];
        logic [3:0] an;
        segs = '{8'hC0, 8'hF9, 8'hA4, 8'hB0};
        for (int d = 0; d < 4; d++) begin
            an = 4'b1111 ^ (4'b0001 << d);
            apply(an, segs[d]);
            repeat (4) @(posedge clk);
            #1;
            total++; if (bus.digit_valid[d] !== 1'b0) begin bad++; $display("FAIL sweep_early d=%0d got=%b exp=0", d, bus.digit_valid[d]); end
            @(posedge clk);
            #1;
            total++; if (bus.digit_valid[d] !== 1'b1) begin bad++; $display("FAIL sweep_ontime d=%0d got=%b exp=1", d, bus.digit_valid[d]); end
            repeat (3) @(posedge clk);
            #1;
        end
        total++; if (bus.value !== 16'h3210) begin bad++; $display("FAIL sweep_value got=%h exp=%h", bus.value, 16'h3210); end
        total++; if (bus.digit_valid !== 4'hF) begin bad++; $display("FAIL sweep_dv got=%h exp=%h", bus.digit_valid, 4'hF); end
        total++; if (fv_cnt !== 1) begin bad++; $display("FAIL sweep_frames got=%0d exp=1", fv_cnt); end
        total++; if (bus.err_flag !== 1'b0) begin bad++; $display("FAIL sweep_err got=%b exp=0", bus.err_flag); end
        total++; if (bus.dp !== 4'h0) begin bad++; $display("FAIL sweep_dp got=%h exp=%h", bus.dp, 4'h0); end
    endtask

    task automatic test_glitch;
        hold(4'b1110, 8'h82, 3);
        apply(4'b1110, 8'hF8);
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus.value[3:0] !== 4'h0) begin bad++; $display("FAIL glitch_no6 got=%h exp=%h", bus.value[3:0], 4'h0); end
        repeat (6) @(posedge clk);
        #1;
        total++; if (bus.value !== 16'h3217) begin bad++; $display("FAIL glitch_value got=%h exp=%h", bus.value, 16'h3217); end
    endtask

    task automatic test_multi_anode;
        hold(4'b1100, 8'hF9, 10);
        total++; if (bus.value !== 16'h3217) begin bad++; $display("FAIL multi_value got=%h exp=%h", bus.value, 16'h3217); end
        total++; if (bus.digit_valid !== 4'hF) begin bad++; $display("FAIL multi_dv got=%h exp=%h", bus.digit_valid, 4'hF); end
        total++; if (dut.state !== 2'd0) begin bad++; $display("FAIL multi_state got=%0d exp=0", dut.state); end
    endtask

    task automatic test_illegal;
        hold(4'b1011, 8'hB6, 8);
        total++; if (bus.err_flag !== 1'b1) begin bad++; $display("FAIL illegal_flag got=%b exp=1", bus.err_flag); end
        total++; if (bus.err_digit !== 3'd2) begin bad++; $display("FAIL illegal_digit got=%0d exp=2", bus.err_digit); end
        total++; if (bus.digit_valid !== 4'b1011) begin bad++; $display("FAIL illegal_dv got=%b exp=1011", bus.digit_valid); end
        total++; if (bus.value !== 16'h3017) begin bad++; $display("FAIL illegal_value got=%h exp=%h", bus.value, 16'h3017); end
        bus.err_clr = 1'b1;
        @(posedge clk);
        #1 bus.err_clr = 1'b0;
        total++; if (bus.err_flag !== 1'b0) begin bad++; $display("FAIL errclr_flag got=%b exp=0", bus.err_flag); end
    endtask

    task automatic test_blank;
        hold(4'b1101, 8'h7F, 8);
        total++; if (bus.value !== 16'h3007) begin bad++; $display("FAIL blank_value got=%h exp=%h", bus.value, 16'h3007); end
        total++; if (bus.digit_valid !== 4'b1001) begin bad++; $display("FAIL blank_dv got=%b exp=1001", bus.digit_valid); end
        total++; if (bus.dp !== 4'b0010) begin bad++; $display("FAIL blank_dp got=%b exp=0010", bus.dp); end
        total++; if (bus.err_flag !== 1'b0) begin bad++; $display("FAIL blank_err got=%b exp=0", bus.err_flag); end
    endtask

    task automatic test_set_wins;
        apply(4'b1110, 8'hB6);
        repeat (4) @(posedge clk);
        #1 bus.err_clr = 1'b1;
        @(posedge clk);
        #1 bus.err_clr = 1'b0;
        total++; if (bus.err_flag !== 1'b1) begin bad++; $display("FAIL setwins_flag got=%b exp=1", bus.err_flag); end
        total++; if (bus.err_digit !== 3'd0) begin bad++; $display("FAIL setwins_digit got=%0d exp=0", bus.err_digit); end
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.value !== 16'h3000) begin bad++; $display("FAIL setwins_value got=%h exp=%h", bus.value, 16'h3000); end
        total++; if (fv_cnt !== 1) begin bad++; $display("FAIL recapture_frames got=%0d exp=1", fv_cnt); end
    endtask

    task automatic test_frame;
        apply(4'b0111, 8'hB0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        total++; if (bus.frame_valid !== 1'b1) begin bad++; $display("FAIL frame_pulse got=%b exp=1", bus.frame_valid); end
        @(negedge clk);
        total++; if (bus.frame_valid !== 1'b0) begin bad++; $display("FAIL frame_width got=%b exp=0", bus.frame_valid); end
        total++; if (fv_cnt !== 2) begin bad++; $display("FAIL frame_count got=%0d exp=2", fv_cnt); end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_qual;
        apply(4'b0111, 8'h8E);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        apply(4'hF, 8'hFF);
        #1;
        total++; if (bus.value !== 16'h0000) begin bad++; $display("FAIL rstq_value got=%h exp=%h", bus.value, 16'h0000); end
        total++; if (bus.digit_valid !== 4'h0) begin bad++; $display("FAIL rstq_dv got=%h exp=%h", bus.digit_valid, 4'h0); end
        total++; if (bus.dp !== 4'h0) begin bad++; $display("FAIL rstq_dp got=%h exp=%h", bus.dp, 4'h0); end
        total++; if ({bus.err_flag, bus.err_digit} !== 4'h0) begin bad++; $display("FAIL rstq_err got=%h exp=0", {bus.err_flag, bus.err_digit}); end
        total++; if (bus.frame_valid !== 1'b0) begin bad++; $display("FAIL rstq_fv got=%b exp=0", bus.frame_valid); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        total++; if (bus.value !== 16'h0000) begin bad++; $display("FAIL rstq_nowrite got=%h exp=%h", bus.value, 16'h0000); end
        hold(4'b0111, 8'h8E, 8);
        total++; if (bus.value !== 16'hF000) begin bad++; $display("FAIL rstq_after_value got=%h exp=%h", bus.value, 16'hF000); end
        total++; if (bus.digit_valid !== 4'b1000) begin bad++; $display("FAIL rstq_after_dv got=%b exp=1000", bus.digit_valid); end
        total++; if (bus.err_flag !== 1'b0) begin bad++; $display("FAIL rstq_after_err got=%b exp=0", bus.err_flag); end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_glitch();
        test_multi_anode();
        test_illegal();
        test_blank();
        test_set_wins();
        test_frame();
        test_reset_mid_qual();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
